// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
package hazard_pkg;

  localparam int HZ_REG_W   = 5;
  localparam int HZ_LAT_W   = 4;
  localparam int FW_REGFILE = 0;

  // Scoreboard entry widths follow HZ_REG_W / HZ_LAT_W; top-level REG_W / LAT_W default to these.
  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rd;
    logic [HZ_LAT_W-1:0] cnt;
  } sb_entry_t;

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of in-flight multi-cycle ops: allocation, countdown, source match, WAW, full.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int SB_DEPTH    = 4,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0][HZ_REG_W-1:0]   src,
  input  logic                               ml_issue,
  input  logic [HZ_REG_W-1:0]                ml_rd,
  input  logic [HZ_LAT_W-1:0]                ml_lat,
  input  logic                               stall,
  output logic [NUM_SRC-1:0]                 src_busy,
  output logic                               waw,
  output logic                               sb_full
);

  sb_entry_t              sb_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]    vld;
  logic [SB_DEPTH-1:0]    alloc_oh;
  logic                   do_alloc;
  logic [HZ_LAT_W-1:0]    lat_ld;

  always_comb begin
    for (int e = 0; e < SB_DEPTH; e++) vld[e] = sb_q[e].valid;
  end

  assign sb_full = &vld;

  // Only slots free at the start of the cycle are candidates, so a retiring slot is never reused same-cycle.
  always_comb begin
    logic taken;
    taken    = 1'b0;
    alloc_oh = '0;
    for (int e = 0; e < SB_DEPTH; e++) begin
      if (!vld[e] && !taken) begin
        alloc_oh[e] = 1'b1;
        taken       = 1'b1;
      end
    end
  end

  always_comb begin
    src_busy = '0;
    waw      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (vld[e] && sb_q[e].rd == src[i] && !(ZERO_REG_EN && src[i] == '0))
          src_busy[i] = 1'b1;
      end
    end
    for (int e = 0; e < SB_DEPTH; e++) begin
      if (ml_issue && vld[e] && sb_q[e].rd == ml_rd) waw = 1'b1;
    end
  end

  assign lat_ld   = (ml_lat == '0) ? HZ_LAT_W'(1) : ml_lat;
  assign do_alloc = ml_issue && !stall && !sb_full && !(ZERO_REG_EN && ml_rd == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < SB_DEPTH; e++) sb_q[e] <= '0;
    end else begin
      for (int e = 0; e < SB_DEPTH; e++) begin
        if (do_alloc && alloc_oh[e]) begin
          sb_q[e] <= '{valid: 1'b1, rd: ml_rd, cnt: lat_ld};
        end else if (sb_q[e].valid) begin
          if (sb_q[e].cnt == HZ_LAT_W'(1)) sb_q[e].valid <= 1'b0;
          sb_q[e].cnt <= sb_q[e].cnt - HZ_LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / multi-cycle stall generation and stall-cycle counter.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W       = HZ_REG_W,
  parameter int NUM_SRC     = 2,
  parameter int NUM_STAGES  = 2,
  parameter int SB_DEPTH    = 4,
  parameter int LAT_W       = HZ_LAT_W,
  parameter bit ZERO_REG_EN = 1'b1,
  localparam int SEL_W      = sel_width(NUM_STAGES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_ex_valid,
  input  logic [NUM_SRC*REG_W-1:0]    id_ex_src,
  input  logic [NUM_STAGES-1:0]       stg_regwrite,
  input  logic [NUM_STAGES*REG_W-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0]       stg_data_late,
  input  logic                        ml_issue,
  input  logic [REG_W-1:0]            ml_rd,
  input  logic [LAT_W-1:0]            ml_lat,
  input  logic                        cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]    fw_sel,
  output logic                        stall,
  output logic                        sb_full,
  output logic [15:0]                 stall_cnt
);

  logic [NUM_SRC-1:0][REG_W-1:0]    src;
  logic [NUM_STAGES-1:0][REG_W-1:0] rd_a;
  logic [NUM_SRC-1:0][SEL_W-1:0]    sel_a;
  logic [NUM_SRC-1:0]               load_use;
  logic [NUM_SRC-1:0]               sb_busy;
  logic                             waw;

  assign src    = id_ex_src;
  assign rd_a   = stg_rd;
  assign fw_sel = sel_a;

  // Scan oldest to youngest so the nearest matching stage overrides.
  always_comb begin
    sel_a    = '0;
    load_use = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_a[i] = SEL_W'(FW_REGFILE);
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (stg_regwrite[k-1] && rd_a[k-1] == src[i] && !(ZERO_REG_EN && rd_a[k-1] == '0)) begin
          sel_a[i]    = SEL_W'(k);
          load_use[i] = stg_data_late[k-1];
        end
      end
    end
  end

  hazard_scoreboard #(
    .NUM_SRC     (NUM_SRC),
    .SB_DEPTH    (SB_DEPTH),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .src      (src),
    .ml_issue (ml_issue),
    .ml_rd    (ml_rd),
    .ml_lat   (ml_lat),
    .stall    (stall),
    .src_busy (sb_busy),
    .waw      (waw),
    .sb_full  (sb_full)
  );

  // Issue-side hazards hold the multi-cycle op upstream even when ID/EX carries a bubble.
  assign stall = (id_ex_valid && (|load_use || |sb_busy)) || (ml_issue && sb_full) || waw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= '0;
    else if (cnt_clr)                    stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard-driven bench: each driven cycle queues its expected outputs, a negedge monitor checks them.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_ex_valid;
  logic [9:0]  id_ex_src;
  logic [1:0]  stg_regwrite;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_data_late;
  logic        ml_issue;
  logic [4:0]  ml_rd;
  logic [3:0]  ml_lat;
  logic        cnt_clr;
  logic [3:0]  fw_sel;
  logic        stall;
  logic        sb_full;
  logic [15:0] stall_cnt;

  typedef struct {
    string       tag;
    logic [3:0]  fw;
    logic        st;
    logic        full;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] cnt_model = '0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_ex_valid   (id_ex_valid),
    .id_ex_src     (id_ex_src),
    .stg_regwrite  (stg_regwrite),
    .stg_rd        (stg_rd),
    .stg_data_late (stg_data_late),
    .ml_issue      (ml_issue),
    .ml_rd         (ml_rd),
    .ml_lat        (ml_lat),
    .cnt_clr       (cnt_clr),
    .fw_sel        (fw_sel),
    .stall         (stall),
    .sb_full       (sb_full),
    .stall_cnt     (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".fw_sel"},    32'(fw_sel),    32'(e.fw));
      chk({e.tag, ".stall"},     32'(stall),     32'(e.st));
      chk({e.tag, ".sb_full"},   32'(sb_full),   32'(e.full));
      chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    end
  end

  task automatic fwd(input logic v, input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] wr,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] late);
    id_ex_valid   = v;
    id_ex_src     = {s1, s0};
    stg_regwrite  = wr;
    stg_rd        = {r2, r1};
    stg_data_late = late;
  endtask

  task automatic ml(input logic iss, input logic [4:0] rd, input logic [3:0] lat);
    ml_issue = iss;
    ml_rd    = rd;
    ml_lat   = lat;
  endtask

  // Queue expectations for the current inputs, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] fw, input logic st, input logic full);
    exp_t e;
    if (!rst_n) cnt_model = '0;
    e.tag = tag; e.fw = fw; e.st = st; e.full = full; e.cnt = cnt_model;
    exp_q.push_back(e);
    if (!rst_n || cnt_clr)                 cnt_model = '0;
    else if (st && cnt_model != 16'hFFFF)  cnt_model = cnt_model + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    fwd(0, 0, 0, 2'b00, 0, 0, 2'b00);
    ml(0, 0, 0);
    @(posedge clk);
    #1;
    cyc("rst", 4'b0000, 0, 0);
    rst_n = 1'b1;
    cyc("idle", 4'b0000, 0, 0);

    // forwarding priority
    fwd(1, 3, 4, 2'b11, 3, 3, 2'b00);  cyc("fw_near", 4'b0001, 0, 0);
    fwd(1, 3, 4, 2'b11, 3, 4, 2'b00);  cyc("fw_two",  4'b1001, 0, 0);

    // load-use and zero register
    fwd(1, 0, 4, 2'b11, 0, 4, 2'b10);  cyc("lu0", 4'b1000, 1, 0);
                                       cyc("lu1", 4'b1000, 1, 0);
    fwd(1, 0, 4, 2'b11, 0, 4, 2'b00);  cyc("lu_rel", 4'b1000, 0, 0);
    fwd(1, 0, 4, 2'b11, 4, 4, 2'b10);  cyc("lu_near", 4'b0100, 0, 0);
    fwd(0, 0, 4, 2'b10, 0, 4, 2'b10);  cyc("lu_inval", 4'b1000, 0, 0);

    // counter clear wins over a stalled cycle
    fwd(1, 0, 4, 2'b10, 0, 4, 2'b10);
    cnt_clr = 1'b1;                    cyc("clr", 4'b1000, 1, 0);
    cnt_clr = 1'b0;
    fwd(1, 0, 0, 2'b00, 0, 0, 2'b00);  cyc("clr_done", 4'b0000, 0, 0);

    // multi-cycle dependency: three stall cycles
    ml(1, 7, 3);                       cyc("ml_iss", 4'b0000, 0, 0);
    ml(0, 0, 0);
    fwd(1, 7, 0, 2'b00, 0, 0, 2'b00);
    for (int n = 0; n < 3; n++)        cyc("ml_wait", 4'b0000, 1, 0);
                                       cyc("ml_go", 4'b0000, 0, 0);

    // fill the scoreboard, block a fifth issue until the first retires
    fwd(1, 0, 0, 2'b00, 0, 0, 2'b00);
    for (int n = 0; n < 4; n++) begin
      ml(1, 5'(8 + n), 8);             cyc("fill", 4'b0000, 0, 0);
    end
    ml(1, 12, 8);
    for (int n = 0; n < 5; n++)        cyc("full_blk", 4'b0000, 1, 1);
                                       cyc("full_free", 4'b0000, 0, 0);

    // WAW on rd 11 (pending until end of next cycle) must not allocate
    ml(1, 11, 8);                      cyc("waw", 4'b0000, 1, 0);
    ml(0, 0, 0);
    fwd(1, 11, 0, 2'b00, 0, 0, 2'b00); cyc("waw_pend", 4'b0000, 1, 0);
                                       cyc("waw_noalloc", 4'b0000, 0, 0);

    // reset mid-operation
    fwd(1, 0, 0, 2'b00, 0, 0, 2'b00);
    rst_n = 1'b0;                      cyc("rst2", 4'b0000, 0, 0);
    rst_n = 1'b1;
    ml(1, 0, 5);                       cyc("zr_iss", 4'b0000, 0, 0);
    for (int n = 0; n < 3; n++) begin
      ml(1, 5'(13 + n), 8);            cyc("pend_iss", 4'b0000, 0, 0);
    end
    ml(0, 0, 0);
    fwd(1, 13, 0, 2'b00, 0, 0, 2'b00); cyc("pend", 4'b0000, 1, 0);
    rst_n = 1'b0;                      cyc("rst_mid", 4'b0000, 0, 0);
    rst_n = 1'b1;                      cyc("post_rst", 4'b0000, 0, 0);

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS datapath. It sits beside the ID/EX register. Each cycle it selects, per ALU source operand, the nearest younger pipeline stage whose pending write matches that source. It raises a stall for load-use hazards and for operands owned by in-flight multi-cycle operations, which it tracks in an internal scoreboard. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- NUM_STAGES, 2, forwarding stages after EX (stage 1 = EX/MEM, stage 2 = MEM/WB, …)
- SB_DEPTH, 4, scoreboard entries for multi-cycle ops
- LAT_W, 4, latency field width
- ZERO_REG_EN, 1, register 0 is hard-wired zero and never forwarded or tracked

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_src  in  NUM_SRC*REG_W  source register addresses (src 0 in the LSBs)
- stg_regwrite  in  NUM_STAGES  stage k writes a register
- stg_rd  in  NUM_STAGES*REG_W  stage k destination
- stg_data_late  in  NUM_STAGES  stage k result not yet available (load in flight)
- ml_issue  in  1  multi-cycle op leaves EX this cycle
- ml_rd  in  REG_W  its destination
- ml_lat  in  LAT_W  its latency in cycles
- cnt_clr  in  1  synchronous clear of stall_cnt
- fw_sel  out  NUM_SRC*SEL_W  per-source select; 0 = register file, k = stage k; SEL_W = clog2(NUM_STAGES+1)
- stall  out  1  hold IF/ID/ID-EX and bubble EX
- sb_full  out  1  all scoreboard entries valid
- stall_cnt  out  16  stall cycles since reset or clear

## Operation
- **Forwarding (combinational).**
  - Stage k matches source i if stg_regwrite[k] is set and stg_rd[k] equals src i.
  - When ZERO_REG_EN is set, a match also requires rd ≠ 0.
  - The lowest matching k wins: fw_sel[i] = k. With no match, fw_sel[i] = 0.
- **Load-use.** If the winning stage has stg_data_late set, the source raises a stall request.
- **Scoreboard.**
  - Each entry holds {valid, rd, cnt}.
  - On ml_issue with stall = 0 and sb_full = 0, the lowest-index free entry loads {1, ml_rd, max(ml_lat, 1)}.
  - Each cycle, every valid entry decrements cnt. An entry with cnt = 1 becomes invalid on the next edge.
  - A slot that frees in a cycle cannot be reallocated in that same cycle.
  - With ZERO_REG_EN set, ml_issue with ml_rd = 0 allocates nothing.
- **Scoreboard stall sources:**
  - a valid entry's rd matches any source;
  - ml_issue while sb_full;
  - ml_issue whose ml_rd matches a valid entry (WAW). No allocation occurs in this case.
- **stall** is the OR of all stall requests, gated by id_ex_valid. The ml_issue terms are not gated by id_ex_valid.
- **stall_cnt**
  - Increments on each cycle with stall = 1 and saturates at 0xFFFF.
  - cnt_clr has priority: that cycle's stall is not counted.

## Timing
- fw_sel and stall are purely combinational, with zero latency. Scoreboard state is registered.
- An issue at edge t with latency L makes the entry valid for cycles t+1 … t+L. A dependent instruction stalls exactly L cycles and proceeds at t+L+1, forwarded through the normal stage ports.
- Reset values:
  - all entries invalid;
  - stall_cnt = 0;
  - sb_full = 0;
  - stall = 0 and fw_sel = 0 whenever the inputs are idle.
- Asserting reset mid-operation discards all pending entries immediately. No stall persists after release.
- Simultaneous events:
  - issue and retire in the same cycle: both take effect, and the retiring slot stays unusable that cycle;
  - issue while stalled: ignored, and upstream holds the issue.

## Structure
- hazard_pkg:
  - sb_entry_t struct;
  - FW_REGFILE = 0 constant;
  - sel_width function (clog2 of NUM_STAGES+1).
- Sub-module hazard_scoreboard holds the entries, allocation, countdown, match vector and sb_full. The top level keeps the forwarding priority logic, the stall OR, and stall_cnt.

## Test plan
- src = {3, 4}; stage 1 rd = 3 and stage 2 rd = 3, both writing → fw_sel[0] = 1, fw_sel[1] = 0, stall = 0.
- src 0 = 0, stage 1 rd = 0 writing → fw_sel[0] = 0. Stage 2 rd = 4 with stg_data_late set, src 1 = 4 → stall = 1 for exactly the cycles data_late is held.
- ml_issue rd = 7, lat = 3 at edge t; the next instruction reads r7 → stall for cycles t+1 … t+3, drops at t+4; stall_cnt = 3.
- Four issues with distinct rd and lat = 8 → sb_full = 1. A fifth issue → stall, no allocation. After the first entry retires, the issue succeeds the following cycle.
- WAW: a pending rd = 5 plus a new issue with rd = 5 → stall, entry count unchanged.
- Assert rst_n = 0 with three entries pending → sb_full = 0, stall = 0 and stall_cnt = 0 immediately. The same source reads no stall after release.
